snitch_icache_tag_array: RTL and testbench



---
 rtl/snitch_icache_tag_array.sv | 171 +++++++++++++++++
 tb/tb_snitch_icache_tag_array.sv | 279 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/snitch_icache_tag_array.sv
// snitch_icache_tag_array
//
// Tag store for a set-associative instruction cache. It holds SET_COUNT ways of
// LINE_COUNT entries, each entry a {valid, tag} pair. A lookup reads all ways of
// one line, compares the tags, and returns hit / lowest hitting way / error one
// cycle after it is accepted. Refills write one entry. After reset, and whenever
// a flush is requested, every line is invalidated, one line per cycle.
//
// Optional feature (compile-time macro):
//   SNITCH_ICACHE_TAG_PARITY_EN - each entry also stores parity = ^{valid, tag}.
//   A way whose parity does not match is kept out of the hit and raises
//   rsp_err_o. Without the macro, no parity bit is stored and rsp_err_o only
//   reports a multi-way hit.
//
// Ports
//   clk_i, rst_i        clock; synchronous active-high reset
//   flush_i             request to invalidate all lines (ignored while flushing)
//   flush_busy_o        a flush is in progress
//   lookup_valid_i/_ready_o, lookup_addr_i, lookup_tag_i   lookup request
//   rsp_valid_o, rsp_hit_o, rsp_way_o, rsp_err_o           lookup response (no backpressure)
//   write_valid_i/_ready_o, write_addr_i, write_way_i, write_tag_i   refill request
//
// state  | meaning
// FLUSH  | invalidating entry [cnt_q] of every way, one line per cycle
// IDLE   | accepting lookups and refills; a refill takes priority over a lookup

module snitch_icache_tag_array #(
   parameter int unsigned SET_COUNT  = 2,
   parameter int unsigned LINE_COUNT = 128,
   parameter int unsigned TAG_WIDTH  = 37,
   localparam int unsigned AW = $clog2(LINE_COUNT),
   localparam int unsigned WW = (SET_COUNT > 1) ? $clog2(SET_COUNT) : 1
) (
   input  logic                 clk_i,
   input  logic                 rst_i,
   input  logic                 flush_i,
   output logic                 flush_busy_o,
   input  logic                 lookup_valid_i,
   output logic                 lookup_ready_o,
   input  logic [AW-1:0]        lookup_addr_i,
   input  logic [TAG_WIDTH-1:0] lookup_tag_i,
   output logic                 rsp_valid_o,
   output logic                 rsp_hit_o,
   output logic                 rsp_err_o,
   output logic [WW-1:0]        rsp_way_o,
   input  logic                 write_valid_i,
   output logic                 write_ready_o,
   input  logic [AW-1:0]        write_addr_i,
   input  logic [WW-1:0]        write_way_i,
   input  logic [TAG_WIDTH-1:0] write_tag_i
);

   typedef enum logic {ST_FLUSH, ST_IDLE} state_e;

   state_e        state_q, state_d;
   logic [AW-1:0] cnt_q, cnt_d;

   logic                 valid_q [SET_COUNT][LINE_COUNT];
   logic [TAG_WIDTH-1:0] tag_q   [SET_COUNT][LINE_COUNT];
`ifdef SNITCH_ICACHE_TAG_PARITY_EN
   logic                 par_q   [SET_COUNT][LINE_COUNT];
`endif

   logic                 lookup_accept, write_accept;
   logic [SET_COUNT-1:0] way_match, par_err;
   logic                 lk_hit, lk_multi, lk_err;
   logic [WW-1:0]        lk_way;

   logic                 rsp_valid_q, rsp_hit_q, rsp_err_q;
   logic [WW-1:0]        rsp_way_q;

   assign flush_busy_o   = (state_q == ST_FLUSH);
   assign write_ready_o  = (state_q == ST_IDLE);
   assign lookup_ready_o = (state_q == ST_IDLE) && !write_valid_i;
   assign lookup_accept  = lookup_valid_i && lookup_ready_o;
   assign write_accept   = write_valid_i && write_ready_o;

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      case (state_q)
         ST_FLUSH: begin
            // Counter wraps back to 0 on the last line since LINE_COUNT is a power of two.
            cnt_d = cnt_q + 1'b1;
            if (cnt_q == AW'(LINE_COUNT - 1)) state_d = ST_IDLE;
         end
         ST_IDLE: begin
            if (flush_i) begin
               state_d = ST_FLUSH;
               cnt_d   = '0;
            end
         end
         default: state_d = ST_FLUSH;
      endcase
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_q     <= ST_FLUSH;
         cnt_q       <= '0;
         rsp_valid_q <= 1'b0;
         rsp_hit_q   <= 1'b0;
         rsp_err_q   <= 1'b0;
         rsp_way_q   <= '0;
      end else begin
         state_q     <= state_d;
         cnt_q       <= cnt_d;
         rsp_valid_q <= lookup_accept;
         rsp_hit_q   <= lookup_accept && lk_hit;
         rsp_err_q   <= lookup_accept && lk_err;
         rsp_way_q   <= lookup_accept ? lk_way : '0;
      end
   end

   // Storage has no reset of its own: the flush that follows every reset clears
   // the valid bits. A write to a way index beyond SET_COUNT matches no way.
   always_ff @(posedge clk_i) begin
      if (!rst_i) begin
         for (int w = 0; w < SET_COUNT; w++) begin
            if (state_q == ST_FLUSH) begin
               valid_q[w][cnt_q] <= 1'b0;
`ifdef SNITCH_ICACHE_TAG_PARITY_EN
               par_q[w][cnt_q]   <= ^tag_q[w][cnt_q];
`endif
            end else if (write_accept && (write_way_i == WW'(w))) begin
               valid_q[w][write_addr_i] <= 1'b1;
               tag_q[w][write_addr_i]   <= write_tag_i;
`ifdef SNITCH_ICACHE_TAG_PARITY_EN
               par_q[w][write_addr_i]   <= ~(^write_tag_i);
`endif
            end
         end
      end
   end

   always_comb begin
      way_match = '0;
      par_err   = '0;
      for (int w = 0; w < SET_COUNT; w++) begin
         way_match[w] = valid_q[w][lookup_addr_i] && (tag_q[w][lookup_addr_i] == lookup_tag_i);
`ifdef SNITCH_ICACHE_TAG_PARITY_EN
         par_err[w]   = par_q[w][lookup_addr_i] != (^{valid_q[w][lookup_addr_i], tag_q[w][lookup_addr_i]});
         way_match[w] = way_match[w] && !par_err[w];
`endif
      end
   end

   // Lowest matching way wins; any further match flags a multi-hit.
   always_comb begin
      lk_hit   = 1'b0;
      lk_multi = 1'b0;
      lk_way   = '0;
      for (int w = 0; w < SET_COUNT; w++) begin
         if (way_match[w]) begin
            if (lk_hit) begin
               lk_multi = 1'b1;
            end else begin
               lk_hit = 1'b1;
               lk_way = WW'(w);
            end
         end
      end
      lk_err = lk_multi || (|par_err);
   end

   assign rsp_valid_o = rsp_valid_q;
   assign rsp_hit_o   = rsp_hit_q;
   assign rsp_err_o   = rsp_err_q;
   assign rsp_way_o   = rsp_way_q;

endmodule

// File: tb/tb_snitch_icache_tag_array.sv
module tb_snitch_icache_tag_array;
   localparam int SETS  = 2;
   localparam int LINES = 128;
   localparam int TW    = 37;
   localparam int AW    = 7;
   localparam int WW    = 1;

   logic          clk_i = 1'b0;
   logic          rst_i, flush_i, flush_busy_o;
   logic          lookup_valid_i, lookup_ready_o;
   logic [AW-1:0] lookup_addr_i;
   logic [TW-1:0] lookup_tag_i;
   logic          rsp_valid_o, rsp_hit_o, rsp_err_o;
   logic [WW-1:0] rsp_way_o;
   logic          write_valid_i, write_ready_o;
   logic [AW-1:0] write_addr_i;
   logic [WW-1:0] write_way_i;
   logic [TW-1:0] write_tag_i;

   always #5 clk_i = ~clk_i;

   snitch_icache_tag_array #(.SET_COUNT(SETS), .LINE_COUNT(LINES), .TAG_WIDTH(TW)) dut (
      .clk_i(clk_i), .rst_i(rst_i), .flush_i(flush_i), .flush_busy_o(flush_busy_o),
      .lookup_valid_i(lookup_valid_i), .lookup_ready_o(lookup_ready_o),
      .lookup_addr_i(lookup_addr_i), .lookup_tag_i(lookup_tag_i),
      .rsp_valid_o(rsp_valid_o), .rsp_hit_o(rsp_hit_o), .rsp_err_o(rsp_err_o), .rsp_way_o(rsp_way_o),
      .write_valid_i(write_valid_i), .write_ready_o(write_ready_o),
      .write_addr_i(write_addr_i), .write_way_i(write_way_i), .write_tag_i(write_tag_i)
   );

   int tests = 0;
   int fails = 0;

   task automatic chk(input string name, input int act, input int exp);
      tests++;
      if (act != exp) begin
         fails++;
         $display("FAIL %s: actual %0d, required %0d", name, act, exp);
      end
   endtask

   // Reference model: plain arrays of what has been written since the last flush.
   bit            m_valid [SETS][LINES];
   logic [TW-1:0] m_tag   [SETS][LINES];

   function automatic void m_flush();
      for (int w = 0; w < SETS; w++)
         for (int a = 0; a < LINES; a++) m_valid[w][a] = 1'b0;
   endfunction

   function automatic void m_write(input int way, input int addr, input logic [TW-1:0] tag);
      if (way < SETS) begin
         m_valid[way][addr] = 1'b1;
         m_tag[way][addr]   = tag;
      end
   endfunction

   function automatic void m_expect(input int addr, input logic [TW-1:0] tag,
                                    output int hit, output int way, output int err);
      int hits[$];
      for (int w = 0; w < SETS; w++)
         if (m_valid[w][addr] && m_tag[w][addr] == tag) hits.push_back(w);
      hit = (hits.size() > 0) ? 1 : 0;
      way = (hits.size() > 0) ? hits[0] : 0;
      err = (hits.size() > 1) ? 1 : 0;
   endfunction

   task automatic tick();
      @(posedge clk_i);
      #1;
   endtask

   task automatic do_write(input int way, input int addr, input logic [TW-1:0] tag);
      write_valid_i = 1'b1;
      write_way_i   = WW'(way);
      write_addr_i  = AW'(addr);
      write_tag_i   = tag;
      #1;
      chk("write_ready", int'(write_ready_o), 1);
      tick();
      write_valid_i = 1'b0;
      m_write(way, addr, tag);
   endtask

   task automatic do_lookup(input int addr, input logic [TW-1:0] tag,
                            output int hit, output int way, output int err);
      lookup_valid_i = 1'b1;
      lookup_addr_i  = AW'(addr);
      lookup_tag_i   = tag;
      #1;
      chk("lookup_ready", int'(lookup_ready_o), 1);
      tick();
      lookup_valid_i = 1'b0;
      chk("rsp_valid", int'(rsp_valid_o), 1);
      hit = int'(rsp_hit_o);
      way = int'(rsp_way_o);
      err = int'(rsp_err_o);
      tick();
      chk("rsp_one_cycle_valid", int'(rsp_valid_o), 0);
      chk("rsp_idle_hit_err", int'({rsp_hit_o, rsp_err_o, rsp_way_o}), 0);
   endtask

   // Counts cycles with flush_busy_o high; optionally pulses flush_i at cycle pulse_at.
   task automatic count_flush(input int pulse_at, output int n, output int bad_ready);
      n = 0;
      bad_ready = 0;
      while (flush_busy_o && n < 400) begin
         if (lookup_ready_o || write_ready_o) bad_ready = 1;
         flush_i = (n == pulse_at);
         tick();
         n++;
      end
      flush_i = 1'b0;
   endtask

   typedef struct {
      bit            is_wr;
      int            way;
      int            addr;
      logic [TW-1:0] tag;
      int            hit;
      int            rway;
      int            err;
   } vec_t;

   vec_t vt[12];

   initial begin
      int n, bad, h, w, e, eh, ew, ee;
      rst_i = 1'b1; flush_i = 1'b0;
      lookup_valid_i = 1'b0; lookup_addr_i = '0; lookup_tag_i = '0;
      write_valid_i = 1'b0; write_addr_i = '0; write_way_i = '0; write_tag_i = '0;
      m_flush();

      vt[0]  = '{1, 1, 'h05, 37'h1234, 0, 0, 0};
      vt[1]  = '{0, 0, 'h05, 37'h1234, 1, 1, 0};
      vt[2]  = '{0, 0, 'h05, 37'h1235, 0, 0, 0};
      vt[3]  = '{1, 0, 'h7F, 37'hAA,   0, 0, 0};
      vt[4]  = '{1, 1, 'h7F, 37'hAA,   0, 0, 0};
      vt[5]  = '{0, 0, 'h7F, 37'hAA,   1, 0, 1};
      vt[6]  = '{0, 0, 'h06, 37'h1234, 0, 0, 0};
      vt[7]  = '{1, 0, 'h05, 37'h1234, 0, 0, 0};
      vt[8]  = '{0, 0, 'h05, 37'h1234, 1, 0, 1};
      vt[9]  = '{1, 1, 'h05, 37'h1FFFFFFFFF, 0, 0, 0};
      vt[10] = '{0, 0, 'h05, 37'h1234, 1, 0, 0};
      vt[11] = '{0, 0, 'h05, 37'h1FFFFFFFFF, 1, 1, 0};

      // Reset state, then the post-reset flush with a lookup waiting.
      tick(); tick();
      chk("rst_rsp", int'({rsp_valid_o, rsp_hit_o, rsp_err_o, rsp_way_o}), 0);
      chk("rst_busy", int'(flush_busy_o), 1);
      chk("rst_write_ready", int'(write_ready_o), 0);
      rst_i = 1'b0;
      lookup_valid_i = 1'b1;
      #1;
      count_flush(-1, n, bad);
      chk("reset_flush_len", n, LINES);
      chk("ready_low_during_flush", bad, 0);
      chk("lookup_ready_after_flush", int'(lookup_ready_o), 1);
      lookup_valid_i = 1'b0;

      // Directed table.
      for (int i = 0; i < 12; i++) begin
         if (vt[i].is_wr) begin
            do_write(vt[i].way, vt[i].addr, vt[i].tag);
         end else begin
            do_lookup(vt[i].addr, vt[i].tag, h, w, e);
            chk($sformatf("vec%0d_hit", i), h, vt[i].hit);
            chk($sformatf("vec%0d_way", i), w, vt[i].rway);
            chk($sformatf("vec%0d_err", i), e, vt[i].err);
         end
      end

      // Random writes and lookups over a small address/tag space to get hits and multi-hits.
      for (int i = 0; i < 300; i++) begin
         int a;
         logic [TW-1:0] t;
         a = int'($urandom_range(0, 7));
         t = TW'($urandom_range(0, 3));
         if ($urandom_range(0, 1) == 0) begin
            do_write(int'($urandom_range(0, SETS - 1)), a, t);
         end else begin
            m_expect(a, t, eh, ew, ee);
            do_lookup(a, t, h, w, e);
            chk("rand_hit", h, eh);
            chk("rand_way", w, ew);
            chk("rand_err", e, ee);
         end
      end

      // Write and lookup presented together: write goes first, lookup sees it next cycle.
      write_valid_i = 1'b1; write_way_i = 1'b0; write_addr_i = 7'h20; write_tag_i = 37'h55;
      lookup_valid_i = 1'b1; lookup_addr_i = 7'h20; lookup_tag_i = 37'h55;
      #1;
      chk("prio_lookup_ready", int'(lookup_ready_o), 0);
      chk("prio_write_ready", int'(write_ready_o), 1);
      tick();
      write_valid_i = 1'b0;
      m_write(0, 'h20, 37'h55);
      chk("prio_no_rsp", int'(rsp_valid_o), 0);
      #1;
      chk("prio_lookup_ready_next", int'(lookup_ready_o), 1);
      tick();
      lookup_valid_i = 1'b0;
      m_expect('h20, 37'h55, eh, ew, ee);
      chk("prio_rsp_valid", int'(rsp_valid_o), 1);
      chk("prio_rsp_hit", int'(rsp_hit_o), eh);
      chk("prio_rsp_way", int'(rsp_way_o), ew);
      tick();

      // Lookup accepted in the cycle flush_i rises still completes.
      m_expect('h20, 37'h55, eh, ew, ee);
      lookup_valid_i = 1'b1; lookup_addr_i = 7'h20; lookup_tag_i = 37'h55;
      flush_i = 1'b1;
      tick();
      lookup_valid_i = 1'b0; flush_i = 1'b0;
      chk("flushrise_rsp_valid", int'(rsp_valid_o), 1);
      chk("flushrise_rsp_hit", int'(rsp_hit_o), eh);
      chk("flushrise_busy", int'(flush_busy_o), 1);
      count_flush(-1, n, bad);
      chk("flushrise_len", n, LINES);
      m_flush();

      // Fill, flush with a second flush_i pulse at cycle 40, then the line is gone.
      do_write(0, 'h10, 37'h77);
      do_write(1, 'h10, 37'h78);
      flush_i = 1'b1;
      tick();
      flush_i = 1'b0;
      count_flush(40, n, bad);
      chk("reflush_len", n, LINES);
      chk("reflush_ready_low", bad, 0);
      m_flush();
      do_lookup('h10, 37'h77, h, w, e);
      chk("after_flush_hit_w0", h, 0);
      do_lookup('h10, 37'h78, h, w, e);
      chk("after_flush_hit_w1", h, 0);

      // Reset mid-lookup drops the response; reset mid-flush restarts from line 0.
      do_write(0, 'h22, 37'h5);
      lookup_valid_i = 1'b1; lookup_addr_i = 7'h22; lookup_tag_i = 37'h5;
      rst_i = 1'b1;
      tick();
      lookup_valid_i = 1'b0; rst_i = 1'b0;
      chk("rst_lookup_rsp", int'(rsp_valid_o), 0);
      chk("rst_lookup_busy", int'(flush_busy_o), 1);
      repeat (50) tick();
      rst_i = 1'b1;
      tick();
      rst_i = 1'b0;
      #1;
      count_flush(-1, n, bad);
      chk("rst_midflush_len", n, LINES);
      m_flush();
      do_lookup('h22, 37'h5, h, w, e);
      chk("rst_cleared_hit", h, 0);

`ifdef SNITCH_ICACHE_TAG_PARITY_EN
      do_write(0, 'h03, 37'h3C);
      dut.tag_q[0][3] = dut.tag_q[0][3] ^ 37'h1;
      do_lookup('h03, 37'h3C, h, w, e);
      chk("par_old_tag_hit", h, 0);
      chk("par_old_tag_err", e, 1);
      do_lookup('h03, 37'h3D, h, w, e);
      chk("par_flipped_tag_hit", h, 0);
      chk("par_flipped_tag_err", e, 1);
`endif

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation time limit reached, tests %0d failed %0d", tests, fails);
      $fatal(1);
   end

endmodule
